// File: rtl/fill_buf.sv
// Cache line fill buffer: requests a missing line from memory, gathers four
// 64-bit beats into a 256-bit line and writes it into the victim way.
module fill_buf #(
  parameter int ADDR_WIDTH = 13,
  parameter int TAG_WIDTH  = 14,
  parameter int WAYS       = 4,
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fill_req,
  input  logic [ADDR_WIDTH-1:0]         fill_idx,
  input  logic [TAG_WIDTH-1:0]          fill_tag,
  input  logic [WAY_W-1:0]              fill_way,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic                          mem_req,
  output logic [TAG_WIDTH+ADDR_WIDTH-1:0] mem_addr,
  input  logic                          mem_ack,
  input  logic                          mem_rvalid,
  input  logic [63:0]                   mem_rdata,
  output logic [WAYS-1:0]               dsram_write,
  output logic [ADDR_WIDTH-1:0]         dsram_aq,
  output logic [31:0]                   dsram_be,
  output logic [255:0]                  dsram_wd
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_COLLECT = 2'd2,
    ST_WRITE   = 2'd3
  } state_e;

  state_e                  state_q;
  logic [1:0]              cnt_q;
  logic [1:0]              cnt_d;
  logic [255:0]            line_q;
  logic [255:0]            line_d;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [WAY_W-1:0]        way_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    mem_req_q;
  logic [WAYS-1:0]         write_q;
  logic [31:0]             be_q;

  function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_W-1:0] w);
    logic [WAYS-1:0] oh;
    oh    = '0;
    oh[w] = 1'b1;
    return oh;
  endfunction

  // Beat insertion: the counter selects which 64-bit lane of the line is loaded.
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q + 2'd1;
    case (cnt_q)
      2'd0:    line_d[63:0]    = mem_rdata;
      2'd1:    line_d[127:64]  = mem_rdata;
      2'd2:    line_d[191:128] = mem_rdata;
      2'd3:    line_d[255:192] = mem_rdata;
      default: line_d          = line_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      line_q    <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      way_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_req_q <= 1'b0;
      write_q   <= '0;
      be_q      <= 32'h0000_0000;
    end else begin
      done_q  <= 1'b0;
      write_q <= '0;
      be_q    <= 32'h0000_0000;
      case (state_q)
        ST_IDLE: begin
          if (fill_req) begin
            idx_q     <= fill_idx;
            tag_q     <= fill_tag;
            way_q     <= fill_way;
            cnt_q     <= 2'd0;
            busy_q    <= 1'b1;
            mem_req_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (mem_rvalid) begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
            // Last beat: the write strobes go out together with the WRITE state.
            if (cnt_q == 2'd3) begin
              done_q  <= 1'b1;
              write_q <= way_onehot(way_q);
              be_q    <= 32'hFFFF_FFFF;
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign fill_busy   = busy_q;
  assign fill_done   = done_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = {tag_q, idx_q};
  assign dsram_write = write_q;
  assign dsram_aq    = idx_q;
  assign dsram_be    = be_q;
  assign dsram_wd    = line_q;

endmodule

// File: tb/tb_fill_buf.sv
// Directed self-checking bench for fill_buf with hand-computed expectations.
module tb_fill_buf;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          fill_req;
  logic [12:0]   fill_idx;
  logic [13:0]   fill_tag;
  logic [1:0]    fill_way;
  logic          fill_busy;
  logic          fill_done;
  logic          mem_req;
  logic [26:0]   mem_addr;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [63:0]   mem_rdata;
  logic [3:0]    dsram_write;
  logic [12:0]   dsram_aq;
  logic [31:0]   dsram_be;
  logic [255:0]  dsram_wd;

  int checks = 0;
  int errors = 0;
  int n_writes = 0;
  int n_done = 0;

  fill_buf #(.ADDR_WIDTH(13), .TAG_WIDTH(14), .WAYS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_req(fill_req), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_way(fill_way),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dsram_write(dsram_write), .dsram_aq(dsram_aq), .dsram_be(dsram_be), .dsram_wd(dsram_wd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dsram_write != 4'b0000) n_writes++;
    if (fill_done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives request, immediate ack and four back-to-back beats; returns in the WRITE cycle.
  task automatic run_fill(input logic [12:0] idx, input logic [13:0] tag, input logic [1:0] way,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3);
    logic [63:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    fill_req = 1'b1; fill_idx = idx; fill_tag = tag; fill_way = way;
    tick();
    fill_req = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1; mem_rdata = b[k];
      tick();
    end
    mem_rvalid = 1'b0; mem_rdata = 64'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", fill_busy); end
    checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", fill_done); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_addr !== 27'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (dsram_write !== 4'b0000) begin errors++; $display("FAIL reset_write got %b exp 0", dsram_write); end
    checks++; if (dsram_aq !== 13'h0) begin errors++; $display("FAIL reset_aq got %h exp 0", dsram_aq); end
    checks++; if (dsram_be !== 32'h0) begin errors++; $display("FAIL reset_be got %h exp 0", dsram_be); end
    checks++; if (dsram_wd !== 256'h0) begin errors++; $display("FAIL reset_wd got %h exp 0", dsram_wd); end
  endtask

  task automatic test_basic_fill();
    logic [63:0] b [4];
    int w0;
    b[0] = 64'h1111_1111_1111_1111; b[1] = 64'h2222_2222_2222_2222;
    b[2] = 64'h3333_3333_3333_3333; b[3] = 64'h4444_4444_4444_4444;
    w0 = n_writes;
    fill_req = 1'b1; fill_idx = 13'h155; fill_tag = 14'h2AB; fill_way = 2'd2;
    tick();
    fill_req = 1'b0;
    checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", fill_busy); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL basic_mem_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== {14'h2AB, 13'h155}) begin errors++; $display("FAIL basic_mem_addr got %h exp %h", mem_addr, {14'h2AB, 13'h155}); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop got %b exp 0", mem_req); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL basic_early_done beat %0d got %b exp 0", k, fill_done); end
      mem_rvalid = 1'b1; mem_rdata = b[k];
      tick();
    end
    mem_rvalid = 1'b0;
    checks++; if (dsram_write !== 4'b0100) begin errors++; $display("FAIL basic_write got %b exp 0100", dsram_write); end
    checks++; if (dsram_aq !== 13'h155) begin errors++; $display("FAIL basic_aq got %h exp 155", dsram_aq); end
    checks++; if (dsram_be !== 32'hFFFF_FFFF) begin errors++; $display("FAIL basic_be got %h exp ffffffff", dsram_be); end
    checks++; if (dsram_wd !== {b[3], b[2], b[1], b[0]}) begin errors++; $display("FAIL basic_wd got %h exp %h", dsram_wd, {b[3], b[2], b[1], b[0]}); end
    checks++; if (fill_done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", fill_done); end
    tick();
    checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", fill_done); end
    checks++; if (dsram_write !== 4'b0000) begin errors++; $display("FAIL basic_write_off got %b exp 0", dsram_write); end
    checks++; if (dsram_be !== 32'h0) begin errors++; $display("FAIL basic_be_off got %h exp 0", dsram_be); end
    checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", fill_busy); end
    checks++; if (dsram_aq !== 13'h155) begin errors++; $display("FAIL basic_aq_hold got %h exp 155", dsram_aq); end
    checks++; if (n_writes - w0 !== 1) begin errors++; $display("FAIL basic_write_count got %0d exp 1", n_writes - w0); end
  endtask

  task automatic test_delayed_ack();
    logic [63:0] b [4];
    int w0;
    b[0] = 64'h0102_0304_0506_0708; b[1] = 64'h1112_1314_1516_1718;
    b[2] = 64'hA1A2_A3A4_A5A6_A7A8; b[3] = 64'hF1F2_F3F4_F5F6_F7F8;
    w0 = n_writes;
    fill_req = 1'b1; fill_idx = 13'h0A3; fill_tag = 14'h1F0; fill_way = 2'd1;
    tick();
    fill_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    mem_rvalid = 1'b0;
    tick(); tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL dack_req_held got %b exp 1", mem_req); end
    mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1; mem_rdata = b[k];
      tick();
      mem_rvalid = 1'b0;
      if (k < 3) begin
        tick(); tick();
        checks++; if (fill_busy !== 1'b1 || dsram_write !== 4'b0000) begin errors++; $display("FAIL dack_gap beat %0d busy %b write %b exp busy 1 write 0", k, fill_busy, dsram_write); end
      end
    end
    checks++; if (dsram_write !== 4'b0010) begin errors++; $display("FAIL dack_write got %b exp 0010", dsram_write); end
    checks++; if (dsram_wd !== {b[3], b[2], b[1], b[0]}) begin errors++; $display("FAIL dack_wd got %h exp %h", dsram_wd, {b[3], b[2], b[1], b[0]}); end
    tick(); tick();
    checks++; if (n_writes - w0 !== 1) begin errors++; $display("FAIL dack_write_count got %0d exp 1", n_writes - w0); end
  endtask

  task automatic test_ignore_second();
    logic [63:0] b [4];
    b[0] = 64'h5555_0000_0000_0001; b[1] = 64'h5555_0000_0000_0002;
    b[2] = 64'h5555_0000_0000_0003; b[3] = 64'h5555_0000_0000_0004;
    fill_req = 1'b1; fill_idx = 13'h010; fill_tag = 14'h0AA; fill_way = 2'd3;
    tick();
    fill_req = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1; mem_rdata = b[k];
      fill_req = (k == 1); fill_idx = (k == 1) ? 13'h1FF : 13'h010;
      tick();
      if (k < 3) begin
        checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL second_busy beat %0d got %b exp 1", k, fill_busy); end
      end
    end
    mem_rvalid = 1'b0; fill_req = 1'b0;
    checks++; if (dsram_aq !== 13'h010) begin errors++; $display("FAIL second_aq got %h exp 010", dsram_aq); end
    checks++; if (dsram_write !== 4'b1000) begin errors++; $display("FAIL second_write got %b exp 1000", dsram_write); end
    checks++; if (mem_addr !== {14'h0AA, 13'h010}) begin errors++; $display("FAIL second_addr got %h exp %h", mem_addr, {14'h0AA, 13'h010}); end
    tick();
    checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL second_no_queue got %b exp 0", fill_busy); end
  endtask

  task automatic test_reset_midfill();
    int w0;
    w0 = n_writes;
    fill_req = 1'b1; fill_idx = 13'h077; fill_tag = 14'h123; fill_way = 2'd0;
    tick();
    fill_req = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hCAFE_0000_0000_0000; tick();
    mem_rdata = 64'hCAFE_0000_0000_0001; tick();
    mem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (fill_busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_async busy %b req %b exp 0 0", fill_busy, mem_req); end
    checks++; if (mem_addr !== 27'h0 || dsram_aq !== 13'h0) begin errors++; $display("FAIL rst_async_addr addr %h aq %h exp 0 0", mem_addr, dsram_aq); end
    checks++; if (dsram_wd !== 256'h0) begin errors++; $display("FAIL rst_async_wd got %h exp 0", dsram_wd); end
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hCAFE_0000_0000_0002; tick();
    mem_rdata = 64'hCAFE_0000_0000_0003; tick();
    mem_rvalid = 1'b0;
    tick();
    checks++; if (fill_busy !== 1'b0 || dsram_wd !== 256'h0) begin errors++; $display("FAIL rst_beats_ignored busy %b wd %h exp 0 0", fill_busy, dsram_wd); end
    checks++; if (n_writes - w0 !== 0) begin errors++; $display("FAIL rst_no_write got %0d exp 0", n_writes - w0); end
    run_fill(13'h1AB, 14'h0F0, 2'd1, 64'h1, 64'h2, 64'h3, 64'h4);
    checks++; if (dsram_write !== 4'b0010 || dsram_aq !== 13'h1AB) begin errors++; $display("FAIL rst_refill write %b aq %h exp 0010 1ab", dsram_write, dsram_aq); end
    checks++; if (dsram_wd !== {64'h4, 64'h3, 64'h2, 64'h1}) begin errors++; $display("FAIL rst_refill_wd got %h exp %h", dsram_wd, {64'h4, 64'h3, 64'h2, 64'h1}); end
    tick();
  endtask

  task automatic test_back_to_back();
    run_fill(13'h100, 14'h001, 2'd0, 64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD);
    checks++; if (fill_done !== 1'b1 || dsram_write !== 4'b0001) begin errors++; $display("FAIL b2b_first done %b write %b exp 1 0001", fill_done, dsram_write); end
    fill_req = 1'b1; fill_idx = 13'h0FE; fill_tag = 14'h3FFF; fill_way = 2'd3;
    tick();
    checks++; if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin errors++; $display("FAIL b2b_idle busy %b done %b exp 0 0", fill_busy, fill_done); end
    tick();
    fill_req = 1'b0;
    checks++; if (fill_busy !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL b2b_accept busy %b req %b exp 1 1", fill_busy, mem_req); end
    checks++; if (mem_addr !== {14'h3FFF, 13'h0FE}) begin errors++; $display("FAIL b2b_addr got %h exp %h", mem_addr, {14'h3FFF, 13'h0FE}); end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h9000_0000_0000_0000; tick();
    mem_rdata = 64'h9100_0000_0000_0000; tick();
    mem_rdata = 64'h9200_0000_0000_0000; tick();
    mem_rdata = 64'h9300_0000_0000_0000; tick();
    mem_rvalid = 1'b0;
    checks++; if (dsram_write !== 4'b1000 || dsram_aq !== 13'h0FE) begin errors++; $display("FAIL b2b_second write %b aq %h exp 1000 0fe", dsram_write, dsram_aq); end
    checks++; if (dsram_wd !== {64'h9300_0000_0000_0000, 64'h9200_0000_0000_0000, 64'h9100_0000_0000_0000, 64'h9000_0000_0000_0000}) begin
      errors++; $display("FAIL b2b_wd got %h", dsram_wd);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; fill_req = 1'b0; fill_idx = 13'h0; fill_tag = 14'h0; fill_way = 2'd0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
    test_reset();
    test_basic_fill();
    test_delayed_ack();
    test_ignore_second();
    test_reset_midfill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
